// File: rtl/fan_light_fade_ctrl.sv
// Fan RGB light command arbiter and fade sequencer: merges button, IR and timer
// commands into color/brightness modes and ramps three 7-bit duties toward the target.
// Build option: FAN_LIGHT_FADE_EN enables the stepped fade; undefined loads targets directly.
`timescale 1ns/1ps
module fan_light_fade_ctrl #(
  parameter int STEP_DIV            = 100_000,
  parameter int NUM_COLOR_MODE      = 7,
  parameter int NUM_BRIGHTNESS_MODE = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_short_pulse,
  input  logic       btn_long_pulse,
  input  logic       ir_valid,
  input  logic [2:0] ir_cmd,
  input  logic       timer_end,
  output logic [6:0] duty_r,
  output logic [6:0] duty_g,
  output logic [6:0] duty_b,
  output logic [2:0] color_mode,
  output logic [1:0] brightness_mode,
  output logic       busy
);

  if (STEP_DIV < 2) begin : g_bad_step_div
    $error("STEP_DIV must be at least 2");
  end

  logic [2:0] r_color;
  logic [1:0] r_bright;
  logic [2:0] w_color_nxt;
  logic [1:0] w_bright_nxt;
  logic [2:0] w_color_inc;
  logic [1:0] w_bright_inc;
  logic [6:0] w_level;
  logic [2:0] w_mask;
  logic [6:0] w_tgt_r;
  logic [6:0] w_tgt_g;
  logic [6:0] w_tgt_b;
  logic [6:0] r_duty_r;
  logic [6:0] r_duty_g;
  logic [6:0] r_duty_b;

  assign w_color_inc  = (r_color == 3'(NUM_COLOR_MODE - 1)) ? 3'd0 : r_color + 3'd1;
  assign w_bright_inc = (r_bright == 2'(NUM_BRIGHTNESS_MODE - 1)) ? 2'd0 : r_bright + 2'd1;

  // ir_valid is a one-cycle strobe with no back-pressure: the command is taken in the
  // cycle it is high unless timer_end outranks it; losing events are simply dropped.
  always_comb begin
    w_color_nxt  = r_color;
    w_bright_nxt = r_bright;
    if (timer_end) begin
      w_bright_nxt = 2'd0;
    end else if (ir_valid) begin
      case (ir_cmd)
        3'd0:    w_color_nxt  = w_color_inc;
        3'd1:    w_bright_nxt = w_bright_inc;
        3'd2:    w_bright_nxt = 2'd0;
        3'd3:    w_bright_nxt = 2'd3;
        default: w_bright_nxt = r_bright;
      endcase
    end else if (btn_long_pulse) begin
      w_bright_nxt = w_bright_inc;
    end else if (btn_short_pulse) begin
      w_color_nxt = w_color_inc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_color  <= 3'd0;
      r_bright <= 2'd0;
    end else begin
      r_color  <= w_color_nxt;
      r_bright <= w_bright_nxt;
    end
  end

  always_comb begin
    case (r_bright)
      2'd0:    w_level = 7'd0;
      2'd1:    w_level = 7'd3;
      2'd2:    w_level = 7'd15;
      default: w_level = 7'd127;
    endcase
  end

  // Mask bits are {red, green, blue}.
  always_comb begin
    case (r_color)
      3'd0:    w_mask = 3'b100;
      3'd1:    w_mask = 3'b010;
      3'd2:    w_mask = 3'b001;
      3'd3:    w_mask = 3'b101;
      3'd4:    w_mask = 3'b011;
      3'd5:    w_mask = 3'b110;
      3'd6:    w_mask = 3'b111;
      default: w_mask = 3'b000;
    endcase
  end

  assign w_tgt_r = w_mask[2] ? w_level : 7'd0;
  assign w_tgt_g = w_mask[1] ? w_level : 7'd0;
  assign w_tgt_b = w_mask[0] ? w_level : 7'd0;

`ifdef FAN_LIGHT_FADE_EN
  typedef enum logic {S_IDLE, S_RAMP} state_t;
  localparam int PW = $clog2(STEP_DIV);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [PW-1:0] r_pre;
  logic [PW-1:0] w_pre_nxt;
  logic [6:0] w_duty_r_nxt;
  logic [6:0] w_duty_g_nxt;
  logic [6:0] w_duty_b_nxt;
  logic [6:0] w_step_r;
  logic [6:0] w_step_g;
  logic [6:0] w_step_b;
  logic       w_mismatch;
  logic       w_step_done;

  function automatic logic [6:0] step_toward(input logic [6:0] cur, input logic [6:0] tgt);
    if (cur < tgt) return cur + 7'd1;
    if (cur > tgt) return cur - 7'd1;
    return cur;
  endfunction

  assign w_step_r    = step_toward(r_duty_r, w_tgt_r);
  assign w_step_g    = step_toward(r_duty_g, w_tgt_g);
  assign w_step_b    = step_toward(r_duty_b, w_tgt_b);
  assign w_mismatch  = (r_duty_r != w_tgt_r) || (r_duty_g != w_tgt_g) || (r_duty_b != w_tgt_b);
  assign w_step_done = (w_step_r == w_tgt_r) && (w_step_g == w_tgt_g) && (w_step_b == w_tgt_b);

  // Targets are re-read at every step, so a retarget mid-ramp keeps the prescaler phase.
  always_comb begin
    w_state_nxt  = r_state;
    w_pre_nxt    = r_pre;
    w_duty_r_nxt = r_duty_r;
    w_duty_g_nxt = r_duty_g;
    w_duty_b_nxt = r_duty_b;
    case (r_state)
      S_IDLE: begin
        if (w_mismatch) begin
          w_state_nxt = S_RAMP;
          w_pre_nxt   = '0;
        end
      end
      default: begin
        if (r_pre == PW'(STEP_DIV - 1)) begin
          w_pre_nxt    = '0;
          w_duty_r_nxt = w_step_r;
          w_duty_g_nxt = w_step_g;
          w_duty_b_nxt = w_step_b;
          if (w_step_done) w_state_nxt = S_IDLE;
        end else begin
          w_pre_nxt = r_pre + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_pre    <= '0;
      r_duty_r <= 7'd0;
      r_duty_g <= 7'd0;
      r_duty_b <= 7'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_pre    <= w_pre_nxt;
      r_duty_r <= w_duty_r_nxt;
      r_duty_g <= w_duty_g_nxt;
      r_duty_b <= w_duty_b_nxt;
    end
  end

  assign busy = (r_state == S_RAMP);
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_duty_r <= 7'd0;
      r_duty_g <= 7'd0;
      r_duty_b <= 7'd0;
    end else begin
      r_duty_r <= w_tgt_r;
      r_duty_g <= w_tgt_g;
      r_duty_b <= w_tgt_b;
    end
  end

  assign busy = 1'b0;
`endif

  assign duty_r          = r_duty_r;
  assign duty_g          = r_duty_g;
  assign duty_b          = r_duty_b;
  assign color_mode      = r_color;
  assign brightness_mode = r_bright;

endmodule

// File: tb/tb_fan_light_fade_ctrl.sv
// Bench for fan_light_fade_ctrl: directed scenarios plus random commands checked every
// cycle against an event-scheduled model of modes, targets and fade steps.
`timescale 1ns/1ps
module tb_fan_light_fade_ctrl;
  localparam int STEP_DIV = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       btn_short_pulse = 1'b0;
  logic       btn_long_pulse = 1'b0;
  logic       ir_valid = 1'b0;
  logic [2:0] ir_cmd = 3'd0;
  logic       timer_end = 1'b0;
  logic [6:0] duty_r, duty_g, duty_b;
  logic [2:0] color_mode;
  logic [1:0] brightness_mode;
  logic       busy;

  int n_checks = 0;
  int n_fail = 0;
  int busy_cycles = 0;

  // reference model state
  int m_color, m_bright, m_busy, m_next_step, e_no;
  int m_duty[3];
  int lvl_tab[4] = '{0, 3, 15, 127};
  logic [2:0] mask_tab[7] = '{3'b100, 3'b010, 3'b001, 3'b101, 3'b011, 3'b110, 3'b111};

  fan_light_fade_ctrl #(
    .STEP_DIV(STEP_DIV),
    .NUM_COLOR_MODE(7),
    .NUM_BRIGHTNESS_MODE(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .btn_short_pulse(btn_short_pulse),
    .btn_long_pulse(btn_long_pulse),
    .ir_valid(ir_valid),
    .ir_cmd(ir_cmd),
    .timer_end(timer_end),
    .duty_r(duty_r),
    .duty_g(duty_g),
    .duty_b(duty_b),
    .color_mode(color_mode),
    .brightness_mode(brightness_mode),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check_eq("duty_r", int'(duty_r), m_duty[0]);
    check_eq("duty_g", int'(duty_g), m_duty[1]);
    check_eq("duty_b", int'(duty_b), m_duty[2]);
    check_eq("color_mode", int'(color_mode), m_color);
    check_eq("brightness_mode", int'(brightness_mode), m_bright);
    check_eq("busy", int'(busy), m_busy);
    if (busy) busy_cycles++;
  endtask

  task automatic model_reset();
    m_color = 0; m_bright = 0; m_busy = 0; m_next_step = 0;
    for (int ch = 0; ch < 3; ch++) m_duty[ch] = 0;
  endtask

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_edge();
    int tgt[3];
    bit all_eq;
    e_no++;
    for (int ch = 0; ch < 3; ch++) tgt[ch] = mask_tab[m_color][2-ch] ? lvl_tab[m_bright] : 0;
`ifdef FAN_LIGHT_FADE_EN
    if (m_busy == 0) begin
      if (m_duty[0] != tgt[0] || m_duty[1] != tgt[1] || m_duty[2] != tgt[2]) begin
        m_busy = 1;
        m_next_step = e_no + STEP_DIV;
      end
    end else if (e_no == m_next_step) begin
      all_eq = 1'b1;
      for (int ch = 0; ch < 3; ch++) begin
        if (m_duty[ch] < tgt[ch]) m_duty[ch]++;
        else if (m_duty[ch] > tgt[ch]) m_duty[ch]--;
        if (m_duty[ch] != tgt[ch]) all_eq = 1'b0;
      end
      if (all_eq) m_busy = 0;
      else m_next_step = m_next_step + STEP_DIV;
    end
`else
    all_eq = 1'b0;
    for (int ch = 0; ch < 3; ch++) m_duty[ch] = tgt[ch];
`endif
    if (timer_end) m_bright = 0;
    else if (ir_valid) begin
      if (ir_cmd == 3'd0) m_color = (m_color + 1) % 7;
      else if (ir_cmd == 3'd1) m_bright = (m_bright + 1) % 4;
      else if (ir_cmd == 3'd2) m_bright = 0;
      else if (ir_cmd == 3'd3) m_bright = 3;
    end else if (btn_long_pulse) m_bright = (m_bright + 1) % 4;
    else if (btn_short_pulse) m_color = (m_color + 1) % 7;
  endtask

  // Called at a falling edge: drive inputs, model the next rising edge, check at the next fall.
  task automatic drive_cycle(input logic t_end, input logic irv, input logic [2:0] irc,
                             input logic bl, input logic bs);
    timer_end = t_end;
    ir_valid = irv;
    ir_cmd = irc;
    btn_long_pulse = bl;
    btn_short_pulse = bs;
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    drive_cycle(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    timer_end = 0; ir_valid = 0; ir_cmd = 0; btn_long_pulse = 0; btn_short_pulse = 0;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_idle(input int max_cycles);
    int i;
    i = 0;
    while (busy && i < max_cycles) begin
      idle();
      i++;
    end
    check_eq("wait_idle_timeout", int'(busy), 0);
  endtask

  initial begin
    int k;
    model_reset();
    e_no = 0;
    @(negedge clk);
    do_reset();

`ifdef FAN_LIGHT_FADE_EN
    // full red ramp: 127 steps of STEP_DIV cycles
    busy_cycles = 0;
    repeat (3) drive_cycle(1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    check_eq("s2_bright", int'(brightness_mode), 3);
    wait_idle(2000);
    check_eq("s2_busy_cycles", busy_cycles, 508);
    check_eq("s2_duty_r", int'(duty_r), 127);
    check_eq("s2_duty_g", int'(duty_g), 0);

    // timer_end wins over IR and button in the same cycle
    do_reset();
    repeat (6) drive_cycle(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    drive_cycle(1'b0, 1'b1, 3'd3, 1'b0, 1'b0);
    wait_idle(2000);
    check_eq("s3_white_b", int'(duty_b), 127);
    drive_cycle(1'b1, 1'b1, 3'd3, 1'b0, 1'b1);
    check_eq("s3_color", int'(color_mode), 6);
    check_eq("s3_bright", int'(brightness_mode), 0);
    wait_idle(2000);
    check_eq("s3_duty_g", int'(duty_g), 0);

    // retarget mid-ramp keeps prescaler phase
    do_reset();
    drive_cycle(1'b0, 1'b1, 3'd3, 1'b0, 1'b0);
    k = 0;
    while (duty_r != 7'd40 && k < 1000) begin
      idle();
      k++;
    end
    check_eq("s4_reach40", int'(duty_r), 40);
    drive_cycle(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    k = 1;
    while (duty_g == 7'd0 && k < 50) begin
      idle();
      k++;
    end
    check_eq("s4_phase", k, STEP_DIV);
    check_eq("s4_r_down", int'(duty_r), 39);
    wait_idle(2000);
    check_eq("s4_r_final", int'(duty_r), 0);
    check_eq("s4_g_final", int'(duty_g), 127);
`else
    // direct-load build: cyan full brightness lands two cycles after the command
    repeat (4) drive_cycle(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    drive_cycle(1'b0, 1'b1, 3'd3, 1'b0, 1'b0);
    check_eq("s6_g_n1", int'(duty_g), 0);
    idle();
    check_eq("s6_r", int'(duty_r), 0);
    check_eq("s6_g", int'(duty_g), 127);
    check_eq("s6_b", int'(duty_b), 127);
    check_eq("s6_busy", int'(busy), 0);
`endif

    // color wrap and ignored IR code
    do_reset();
    drive_cycle(1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    repeat (7) drive_cycle(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    check_eq("s5_wrap", int'(color_mode), 0);
    drive_cycle(1'b0, 1'b1, 3'd5, 1'b1, 1'b1);
    check_eq("s5_ign_color", int'(color_mode), 0);
    check_eq("s5_ign_bright", int'(brightness_mode), 1);

    // random command traffic
    for (int i = 0; i < 4000; i++) begin
      drive_cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 19) == 0),
                  3'($urandom_range(0, 7)), ($urandom_range(0, 24) == 0),
                  ($urandom_range(0, 14) == 0));
    end

    // asynchronous reset in the middle of a ramp
    do_reset();
    drive_cycle(1'b0, 1'b1, 3'd3, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
    repeat (10) idle();
    check_eq("pre_reset_nonzero", (duty_r != 0 || duty_g != 0) ? 1 : 0, 1);
    do_reset();
    repeat (3) idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
